// File: rtl/exmem_pkg.sv
// EX->MEM stage shared definitions: default field widths, payload layout, bubble constant.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exmem_pkg;

    localparam int EXMEM_DATA_W      = 16;
    localparam int EXMEM_REG_ID_W    = 4;
    localparam int EXMEM_WB_W        = 4;
    localparam int EXMEM_FLAG_W      = 3;
    localparam int EXMEM_MEM_W       = 2;
    localparam int EXMEM_STALL_CNT_W = 16;

    // Payload at default widths; field order is wb (MSB) down to src2 (LSB)
    typedef struct packed {
        logic [EXMEM_WB_W-1:0]     wb;     // {RegWrite,MemtoReg,PCtoReg,Halt}
        logic [EXMEM_MEM_W-1:0]    mem;    // {MemWrite,MemRead}
        logic [EXMEM_FLAG_W-1:0]   flags;  // {Z,V,N}
        logic [EXMEM_DATA_W-1:0]   alu;
        logic [EXMEM_DATA_W-1:0]   regd;
        logic [EXMEM_DATA_W-1:0]   rt;
        logic [EXMEM_REG_ID_W-1:0] dst;
        logic [EXMEM_REG_ID_W-1:0] src2;
    } exmem_payload_t;

    localparam exmem_payload_t EXMEM_BUBBLE = '0;

endpackage

// File: rtl/exmem_slot.sv
// One payload+valid register with load and clear; clear beats load.
// Latency: 1 cycle from load to output.
// Backpressure: none internally; the parent decides when to load or clear.
module exmem_slot #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] dat_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o
);

    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;

    // Next state: clear drops valid but leaves data alone so outputs hold their last value
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (clear_i) begin
            vld_d = 1'b0;
        end else if (load_i) begin
            vld_d = 1'b1;
            dat_d = dat_i;
        end
    end

    // State register, async reset empties the slot and zeroes the payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/exmem_stage_pipe.sv
// EX->MEM pipeline register with valid/ready, flush, bubble masking and a saturating stall counter.
// Latency: 1 cycle. Optional skid slot under EXMEM_SKID_EN makes in_ready register-only.
// Backpressure: out_ready=0 holds the beat; in_ready drops (immediately, or once the skid fills).
module exmem_stage_pipe
    import exmem_pkg::*;
#(
    parameter int DATA_W      = EXMEM_DATA_W,
    parameter int REG_ID_W    = EXMEM_REG_ID_W,
    parameter int WB_W        = EXMEM_WB_W,
    parameter int FLAG_W      = EXMEM_FLAG_W,
    parameter int STALL_CNT_W = EXMEM_STALL_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WB_W-1:0]        wb_in,
    input  logic [1:0]             mem_in,
    input  logic [FLAG_W-1:0]      flags_in,
    input  logic [DATA_W-1:0]      alu_data_in,
    input  logic [DATA_W-1:0]      reg_data_in,
    input  logic [DATA_W-1:0]      rt_in,
    input  logic [REG_ID_W-1:0]    dst_reg_in,
    input  logic [REG_ID_W-1:0]    src2_reg_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WB_W-1:0]        wb_out,
    output logic                   mem_write,
    output logic                   mem_read,
    output logic [FLAG_W-1:0]      flags_out,
    output logic [DATA_W-1:0]      alu_data_out,
    output logic [DATA_W-1:0]      reg_data_out,
    output logic [DATA_W-1:0]      rt_out,
    output logic [REG_ID_W-1:0]    dst_reg_out,
    output logic [REG_ID_W-1:0]    src2_reg_out,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // Same layout as exmem_payload_t, but sized by this instance's parameters
    typedef struct packed {
        logic [WB_W-1:0]     wb;
        logic [1:0]          mem;
        logic [FLAG_W-1:0]   flags;
        logic [DATA_W-1:0]   alu;
        logic [DATA_W-1:0]   regd;
        logic [DATA_W-1:0]   rt;
        logic [REG_ID_W-1:0] dst;
        logic [REG_ID_W-1:0] src2;
    } payload_t;

    localparam int PAY_W = $bits(payload_t);

    payload_t in_pay, main_src, main_pay;
    logic     main_vld, main_load, main_clear;
    logic     accept, out_fire;

    // Gather the incoming beat into one payload word
    always_comb begin
        in_pay       = '0;
        in_pay.wb    = wb_in;
        in_pay.mem   = mem_in;
        in_pay.flags = flags_in;
        in_pay.alu   = alu_data_in;
        in_pay.regd  = reg_data_in;
        in_pay.rt    = rt_in;
        in_pay.dst   = dst_reg_in;
        in_pay.src2  = src2_reg_in;
    end

    assign out_fire = main_vld & out_ready;
    // A beat taken during flush is acknowledged upstream but never stored
    assign accept   = in_valid & in_ready & ~flush;

`ifdef EXMEM_SKID_EN
    logic     skid_vld, skid_load, skid_clear;
    payload_t skid_pay;

    // in_ready depends only on the skid register, cutting the out_ready->in_ready path
    assign in_ready   = flush | ~skid_vld;
    // Skid catches a beat when main is stalled, or refills as its beat moves to main
    assign skid_load  = accept & (skid_vld | (main_vld & ~out_ready));
    assign skid_clear = flush | (skid_vld & out_fire & ~skid_load);
    // An older skid beat always goes to main before anything newer
    assign main_src   = skid_vld ? skid_pay : in_pay;
    assign main_load  = skid_vld ? out_fire : (accept & (~main_vld | out_fire));

    exmem_slot #(.W(PAY_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .dat_i   (in_pay),
        .vld_o   (skid_vld),
        .dat_o   (skid_pay)
    );
`else
    // in_ready only ever allows a beat when main is empty or draining this cycle
    assign in_ready  = flush | ~main_vld | out_ready;
    assign main_src  = in_pay;
    assign main_load = accept;
`endif

    // Flush wins; otherwise a drained beat leaves unless replaced in the same cycle
    assign main_clear = flush | (out_fire & ~main_load);

    exmem_slot #(.W(PAY_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (main_load),
        .clear_i (main_clear),
        .dat_i   (main_src),
        .vld_o   (main_vld),
        .dat_o   (main_pay)
    );

    // Side-effect controls read 0 on a bubble; data fields keep their last value
    always_comb begin
        out_valid    = main_vld;
        wb_out       = main_vld ? main_pay.wb : '0;
        mem_write    = main_vld & main_pay.mem[1];
        mem_read     = main_vld & main_pay.mem[0];
        flags_out    = main_pay.flags;
        alu_data_out = main_pay.alu;
        reg_data_out = main_pay.regd;
        rt_out       = main_pay.rt;
        dst_reg_out  = main_pay.dst;
        src2_reg_out = main_pay.src2;
    end

    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count stalled output cycles, sticking at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_vld && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // Stall counter register, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_exmem_stage_pipe.sv
// Scoreboard bench for exmem_stage_pipe: FIFO reference model of accepted beats, flush empties it.
// Latency: checks 1-cycle delivery when not stalled.
// Backpressure: random and directed out_ready stalls; in_valid held until accepted.
module tb_exmem_stage_pipe;

    typedef struct packed {
        logic [3:0]  wb;
        logic [1:0]  mem;
        logic [2:0]  flags;
        logic [15:0] alu;
        logic [15:0] regd;
        logic [15:0] rt;
        logic [3:0]  dst;
        logic [3:0]  src2;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  flush = 1'b0;
    logic  in_valid = 1'b0;
    logic  out_ready = 1'b0;
    beat_t in_b = '0;

    logic        in_ready, out_valid, mem_write, mem_read;
    logic [3:0]  wb_out, dst_reg_out, src2_reg_out;
    logic [2:0]  flags_out;
    logic [15:0] alu_data_out, reg_data_out, rt_out, stall_cnt;

    logic        x_in_ready, x_out_valid, x_mem_write, x_mem_read;
    logic [3:0]  x_wb_out, x_dst, x_src2, x_stall_cnt;
    logic [2:0]  x_flags;
    logic [15:0] x_alu, x_reg, x_rt;

    exmem_stage_pipe dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .wb_in(in_b.wb), .mem_in(in_b.mem), .flags_in(in_b.flags), .alu_data_in(in_b.alu),
        .reg_data_in(in_b.regd), .rt_in(in_b.rt), .dst_reg_in(in_b.dst), .src2_reg_in(in_b.src2),
        .out_valid(out_valid), .out_ready(out_ready), .wb_out(wb_out), .mem_write(mem_write),
        .mem_read(mem_read), .flags_out(flags_out), .alu_data_out(alu_data_out),
        .reg_data_out(reg_data_out), .rt_out(rt_out), .dst_reg_out(dst_reg_out),
        .src2_reg_out(src2_reg_out), .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance for the saturation check, driven in parallel
    exmem_stage_pipe #(.STALL_CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(x_in_ready),
        .wb_in(in_b.wb), .mem_in(in_b.mem), .flags_in(in_b.flags), .alu_data_in(in_b.alu),
        .reg_data_in(in_b.regd), .rt_in(in_b.rt), .dst_reg_in(in_b.dst), .src2_reg_in(in_b.src2),
        .out_valid(x_out_valid), .out_ready(out_ready), .wb_out(x_wb_out), .mem_write(x_mem_write),
        .mem_read(x_mem_read), .flags_out(x_flags), .alu_data_out(x_alu),
        .reg_data_out(x_reg), .rt_out(x_rt), .dst_reg_out(x_dst),
        .src2_reg_out(x_src2), .stall_cnt(x_stall_cnt)
    );

    initial forever #5 clk = ~clk;

    beat_t obs;
    assign obs = {wb_out, mem_write, mem_read, flags_out, alu_data_out, reg_data_out,
                  rt_out, dst_reg_out, src2_reg_out};

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    beat_t       sb[$];
    logic [15:0] seen[$];
    int          seen_cyc[$];
    beat_t       exp_b;
    bit          mon_on = 1'b0;
    bit          rnd    = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        b.wb    = 4'($urandom);
        b.mem   = 2'($urandom);
        b.flags = 3'($urandom);
        b.alu   = 16'($urandom);
        b.regd  = 16'($urandom);
        b.rt    = 16'($urandom);
        b.dst   = 4'($urandom);
        b.src2  = 4'($urandom);
        return b;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Random backpressure when enabled
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: every output transfer must match the oldest expected beat
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            if (out_valid) begin
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", {16'h0, alu_data_out}, 32'hFFFF_FFFF);
                    end else begin
                        exp_b = sb.pop_front();
                        chk("beat", obs, exp_b);
                        seen.push_back(alu_data_out);
                        seen_cyc.push_back(cyc);
                    end
                end
            end else begin
                chk("bubble_ctrl", {wb_out, mem_write, mem_read}, 0);
            end
        end
    end

    // Offer one beat (held until accepted); a flush beat is discarded and empties the model
    task automatic send(input beat_t b, input bit fl);
        bit r;
        bit done;
        done = 1'b0;
        #1;
        in_b = b; in_valid = 1'b1; flush = fl;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            if (fl) begin
                sb.delete();
                done = 1'b1;
            end else if (r) begin
                sb.push_back(b);
                done = 1'b1;
            end
        end
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset();
        #1;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        sb.delete(); seen.delete(); seen_cyc.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        beat_t b, b2, c;
        bit    skid;
`ifdef EXMEM_SKID_EN
        skid = 1'b1;
`else
        skid = 1'b0;
`endif
        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_payload", obs, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        mon_on = 1'b1;

        // Reset mid-beat clears outputs without a clock edge
        out_ready = 1'b0;
        b = rand_beat(); b.alu = 16'hBEEF; b.mem = 2'b10;
        send(b, 0);
        idle(0);
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_mem_write", mem_write, 0);
        chk("midrst_alu", alu_data_out, 0);
        chk("midrst_stall_cnt", stall_cnt, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);

        // Streaming 1..8 with out_ready high
        #1 out_ready = 1'b1;
        @(posedge clk);
        fork
            begin
                for (int i = 1; i <= 8; i++) begin
                    b = rand_beat(); b.alu = 16'(i);
                    send(b, 0);
                end
                idle(0);
            end
            begin
                @(posedge clk);
                for (int i = 1; i <= 8; i++) begin
                    @(negedge clk);
                    chk("stream_valid", out_valid, 1);
                    chk("stream_alu", alu_data_out, 16'(i));
                    chk("stream_in_ready", in_ready, 1);
                end
            end
        join
        @(posedge clk);
        chk("stream_stall_cnt", stall_cnt, 0);

        // Stall for 5 cycles with a second beat offered
        do_reset();
        #1 out_ready = 1'b0;
        b = rand_beat(); b.alu = 16'h0042; b.mem = 2'b10;
        send(b, 0);
        b2 = rand_beat(); b2.alu = 16'h0043;
        #1 in_b = b2; in_valid = 1'b1; flush = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, (skid && k == 0) ? 1 : 0);
            chk("stall_alu", alu_data_out, 16'h0042);
            chk("stall_mem_write", mem_write, 1);
            chk("stall_valid", out_valid, 1);
            @(posedge clk);
            if (skid && k == 0) begin
                sb.push_back(b2);
                #1 in_valid = 1'b0;
            end
        end
        #1;
        chk("stall_cnt5", stall_cnt, 5);

        // Flush during stall with a beat offered: all of it disappears
        c = rand_beat(); c.alu = 16'hDEAD; c.mem = 2'b11; c.wb = 4'hF;
        in_b = c; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 1);
        @(posedge clk);
        sb.delete();
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_mem_write", mem_write, 0);
        chk("flush_wb_out", wb_out, 0);
        chk("flush_in_ready2", in_ready, 1);
        chk("flush_data_hold", alu_data_out, 16'h0042);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (4) @(posedge clk);

        // Two beats during a stall leave in order on consecutive cycles
        #1 out_ready = 1'b0;
        seen.delete(); seen_cyc.delete();
        fork
            begin
                b = rand_beat(); b.alu = 16'h0001; send(b, 0);
                b = rand_beat(); b.alu = 16'h0002; send(b, 0);
                idle(0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        chk("order_count", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("order_first", seen[0], 16'h0001);
            chk("order_second", seen[1], 16'h0002);
            chk("order_back_to_back", seen_cyc[1] - seen_cyc[0], 1);
        end

        // Counter saturation on the 4-bit instance, exact count on the 16-bit one
        do_reset();
        #1 out_ready = 1'b0;
        send(rand_beat(), 0);
        idle(0);
        repeat (20) @(posedge clk);
        #1;
        chk("sat_cnt4", x_stall_cnt, 4'hF);
        chk("sat_cnt16", stall_cnt, 20);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_cnt4_hold", x_stall_cnt, 4'hF);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Random traffic, random stalls, occasional flush
        do_reset();
        rnd = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(rand_beat(), ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
        end
        idle(0);
        rnd = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
        @(posedge clk);
        chk("drain_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
